data_mem_responder: RTL and testbench

Memory-side responder for the core's data port: accepts the read/write strobes, address and write data the execute stage drives, and returns read data.
- Holds a word-addressed data array internally.
- Inserts a configurable number of wait states per access and signals completion with a one-cycle ready pulse.
- Lets the core be moved from single-cycle ideal memory to a stall-capable memory model.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_array.sv | 38 +++
 rtl/data_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the data-memory responder.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - latched operation encoding (OP_RD / OP_WR)
//   - default geometry and wait-state constants
//   - error-cause codes recorded at request capture
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_DEPTH_DEF  = 1024;
    localparam int MEM_ADDR_W_DEF = 10;
    localparam int MEM_WAIT_DEF   = 2;
    localparam int MEM_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } mem_err_e;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |byte_off;
    endfunction

endpackage

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Single-port synchronous word RAM. Write and read share one index; the read
// port is registered and returns the word as it was before a same-cycle write.
// Contents have no reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   idx    in   word index [ADDR_W-1:0]
//   wdata  in   write data [31:0]
//   rdata  out  registered read data [31:0]
// ---------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH_DEF,
    parameter int ADDR_W = MEM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core data port. Captures one request from
// IDLE, waits WAIT_CYCLES states, then performs the access and pulses
// memReady for one cycle (with memErr if the access was rejected).
//
// Build option: MEM_RANGE_CHECK_EN
//   defined   - byte addresses at or above DEPTH*4 are rejected
//   undefined - upper address bits are ignored, index wraps modulo DEPTH
//
// Ports:
//   clk           in   core clock
//   rst           in   synchronous active-high reset
//   memoryRead    in   read strobe
//   writeFlag     in   write strobe (wins over memoryRead)
//   addressIn     in   byte address [31:0]
//   dataOut       in   write data [31:0]
//   memoryDataIn  out  read data, held until the next completed read
//   memReady      out  one-cycle completion pulse
//   memBusy       out  high from capture through the memReady cycle
//   memErr        out  one-cycle reject pulse, coincident with memReady
//
// State | meaning
// IDLE  | waiting for a strobe (capture blocked while memBusy is still high)
// WAIT  | wait states; counter runs down to 0
// RESP  | access performed at the edge leaving this state; memReady follows
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH_DEF,
    parameter int ADDR_W      = MEM_ADDR_W_DEF,
    parameter int WAIT_CYCLES = MEM_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memoryRead,
    input  logic        writeFlag,
    input  logic [31:0] addressIn,
    input  logic [31:0] dataOut,
    output logic [31:0] memoryDataIn,
    output logic        memReady,
    output logic        memBusy,
    output logic        memErr
);

    localparam logic [MEM_CNT_W-1:0] WAIT_LOAD =
        MEM_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    mem_state_e            state_q, state_d;
    logic [MEM_CNT_W-1:0]  cnt_q, cnt_d;
    mem_op_e               op_q, op_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    mem_err_e              cause_q, cause_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [31:0]           dout_q, dout_d;

    mem_err_e              req_cause;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_idx;
    logic [31:0]           ram_rdata;

    // Reject classification of the request currently on the bus.
`ifdef MEM_RANGE_CHECK_EN
    always_comb begin
        req_cause = ERR_NONE;
        if (is_misaligned(addressIn[1:0])) begin
            req_cause = ERR_MISALIGN;
        end else if (|addressIn[31:ADDR_W+2]) begin
            req_cause = ERR_RANGE;
        end
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addressIn[31:ADDR_W+2];

    always_comb begin
        req_cause = ERR_NONE;
        if (is_misaligned(addressIn[1:0])) begin
            req_cause = ERR_MISALIGN;
        end
    end
`endif

    // The RAM read port is registered, so it is addressed with the incoming
    // index while idle; the word is then ready in the cycle after capture,
    // which is already the RESP cycle when WAIT_CYCLES is 0.
    assign ram_idx = (state_q == IDLE) ? addressIn[ADDR_W+1:2] : idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        cause_d = cause_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        dout_d  = dout_q;
        ram_we  = 1'b0;

        case (state_q)
            IDLE: begin
                // busy_q is still high during the memReady cycle, which keeps
                // a held strobe from being captured a second time.
                if (!busy_q && (memoryRead || writeFlag)) begin
                    op_d    = writeFlag ? OP_WR : OP_RD;
                    idx_d   = addressIn[ADDR_W+1:2];
                    wdata_d = dataOut;
                    cause_d = req_cause;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else if (ready_q) begin
                    busy_d = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (cause_q == ERR_NONE) begin
                    if (op_q == OP_WR) begin
                        ram_we = 1'b1;
                    end else begin
                        dout_d = ram_rdata;
                    end
                end else begin
                    err_d = 1'b1;
                    if (op_q == OP_RD) begin
                        dout_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
            cause_q <= ERR_NONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            cause_q <= cause_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // A reset landing on the RESP cycle must still discard the write.
    mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we && !rst),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign memoryDataIn = dout_q;
    assign memReady     = ready_q;
    assign memBusy      = busy_q;
    assign memErr       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    typedef struct {
        int          lat;
        logic [31:0] data;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_s, wr_s;
    logic [31:0] addr_s, data_s;
    int          sel;

    logic        rd_w2, wr_w2, rd_w0, wr_w0;
    logic [31:0] dout_w2, dout_w0;
    logic        rdy_w2, rdy_w0, busy_w2, busy_w0, err_w2, err_w0;
    logic [31:0] cur_dout;
    logic        cur_rdy, cur_busy, cur_err;

    int          errors = 0;
    int          checks = 0;

    sb_t         sb[$];
    logic [31:0] mdl [int];
    logic [31:0] last_dout [2];
    int          wc [2];

    always #5 clk = ~clk;

    assign rd_w2 = rd_s & (sel == 0);
    assign wr_w2 = wr_s & (sel == 0);
    assign rd_w0 = rd_s & (sel == 1);
    assign wr_w0 = wr_s & (sel == 1);

    assign cur_dout = (sel == 0) ? dout_w2 : dout_w0;
    assign cur_rdy  = (sel == 0) ? rdy_w2  : rdy_w0;
    assign cur_busy = (sel == 0) ? busy_w2 : busy_w0;
    assign cur_err  = (sel == 0) ? err_w2  : err_w0;

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .memoryRead(rd_w2), .writeFlag(wr_w2),
        .addressIn(addr_s), .dataOut(data_s), .memoryDataIn(dout_w2),
        .memReady(rdy_w2), .memBusy(busy_w2), .memErr(err_w2)
    );

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .memoryRead(rd_w0), .writeFlag(wr_w0),
        .addressIn(addr_s), .dataOut(data_s), .memoryDataIn(dout_w0),
        .memReady(rdy_w0), .memBusy(busy_w0), .memErr(err_w0)
    );

    // One full access on instance w: expectation pushed at drive time, popped
    // when memReady is seen. Strobe is held through the memReady cycle and one
    // edge beyond, so a re-capture would show up as memBusy.
    task automatic access(input int w, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input string nm);
        sb_t  e;
        sb_t  got;
        logic bad;
        int   key;
        int   lat;
        sel = w; rd_s = rd; wr_s = wr; addr_s = a; data_s = d;
        bad = (a[1:0] != 2'b00);
`ifdef MEM_RANGE_CHECK_EN
        bad = bad | (|a[31:12]);
`endif
        key = w * 4096 + int'(a[11:2]);
        if (wr) begin
            if (!bad) mdl[key] = d;
            e.data = last_dout[w];
        end else begin
            e.data = bad ? 32'h0 : mdl[key];
            last_dout[w] = e.data;
        end
        e.err = bad;
        e.lat = wc[w] + 1;
        sb.push_back(e);

        @(posedge clk); #1;
        checks++;
        if (cur_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_capture got=%b exp=1", nm, cur_busy);
        end
        lat = 0;
        while (cur_rdy !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            checks++;
            if (cur_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_while_pending got=%b exp=1 cyc=%0d", nm, cur_busy, lat);
            end
        end
        got = sb.pop_front();
        checks++;
        if (cur_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout got=%b exp=1 after %0d cycles", nm, cur_rdy, lat);
        end else begin
            checks++;
            if (lat !== got.lat) begin
                errors++;
                $display("FAIL %s latency got=%0d exp=%0d", nm, lat, got.lat);
            end
            checks++;
            if (cur_dout !== got.data) begin
                errors++;
                $display("FAIL %s data got=%h exp=%h", nm, cur_dout, got.data);
            end
            checks++;
            if (cur_err !== got.err) begin
                errors++;
                $display("FAIL %s err got=%b exp=%b", nm, cur_err, got.err);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (cur_rdy !== 1'b0 || cur_busy !== 1'b0 || cur_err !== 1'b0) begin
            errors++;
            $display("FAIL %s after_ready rdy/busy/err got=%b%b%b exp=000",
                     nm, cur_rdy, cur_busy, cur_err);
        end
        rd_s = 1'b0; wr_s = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cur_busy !== 1'b0 || cur_dout !== got.data) begin
            errors++;
            $display("FAIL %s no_recapture busy got=%b exp=0 data got=%h exp=%h",
                     nm, cur_busy, cur_dout, got.data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_s = 1'b0; wr_s = 1'b0; addr_s = '0; data_s = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rdy_w2, busy_w2, err_w2, rdy_w0, busy_w0, err_w0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {rdy_w2, busy_w2, err_w2, rdy_w0, busy_w0, err_w0});
        end
        checks++;
        if (dout_w2 !== 32'h0 || dout_w0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h exp=0/0", dout_w2, dout_w0);
        end
        rst = 1'b0;
        last_dout[0] = 32'h0;
        last_dout[1] = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_wait2_write_read();
        access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, "w2_write_40");
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, "w2_read_40");
    endtask

    task automatic test_back_to_back();
        access(1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, "w0_write_40");
        access(1, 1'b0, 1'b1, 32'h44, 32'h12345678, "w0_write_44");
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, "w0_read_40");
        access(1, 1'b1, 1'b0, 32'h44, 32'h0, "w0_read_44");
    endtask

    task automatic test_misaligned();
        access(0, 1'b1, 1'b0, 32'h42, 32'h0, "misaligned_read_42");
        access(0, 1'b0, 1'b1, 32'h41, 32'h0000AAAA, "misaligned_write_41");
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, "read_40_after_bad_write");
    endtask

    task automatic test_both_strobes();
        access(0, 1'b1, 1'b1, 32'h80, 32'h55, "both_strobes_80");
        access(0, 1'b1, 1'b0, 32'h80, 32'h0, "read_80");
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        access(0, 1'b0, 1'b1, 32'h100, 32'hCAFE0001, "prior_write_100");
        sel = 0; wr_s = 1'b1; rd_s = 1'b0; addr_s = 32'h100; data_s = 32'h99;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rdy_w2 !== 1'b0 || busy_w2 !== 1'b0 || err_w2 !== 1'b0 || dout_w2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_write outputs got rdy=%b busy=%b err=%b data=%h exp=0",
                     rdy_w2, busy_w2, err_w2, dout_w2);
        end
        rst = 1'b0; wr_s = 1'b0;
        last_dout[0] = 32'h0;
        last_dout[1] = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rdy_w2 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write spurious_ready got=%b exp=0", seen);
        end
        access(0, 1'b1, 1'b0, 32'h100, 32'h0, "read_100_after_reset");
    endtask

    task automatic test_range();
        access(0, 1'b0, 1'b1, 32'h0, 32'h77, "w2_write_0");
        access(0, 1'b1, 1'b0, 32'h1000, 32'h0, "w2_read_1000");
        access(1, 1'b0, 1'b1, 32'h0, 32'h77, "w0_write_0");
        access(1, 1'b1, 1'b0, 32'h1000, 32'h0, "w0_read_1000");
        access(1, 1'b0, 1'b1, 32'h1008, 32'h31337, "w0_write_1008");
        access(1, 1'b1, 1'b0, 32'h8, 32'h0, "w0_read_8");
    endtask

    initial begin
        wc[0] = 2;
        wc[1] = 0;
        mdl[2] = 32'h0;
        mdl[4096 + 2] = 32'h0;
        test_reset();
        test_wait2_write_read();
        test_back_to_back();
        test_misaligned();
        test_both_strobes();
        test_reset_mid_write();
        test_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
